// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program counter with branch resolution for KGP-RISC
//
// Each enabled cycle (instr_valid & ~stall) the branch class, function code and
// ALU flags select the next PC. The unit also produces a one-cycle taken pulse,
// link data for bl, and a saturating count of taken redirects.
//
// Build option: define PC_SEQ_RAS_EN to add a RAS_DEPTH-entry circular
// return-address stack. bl pushes and ret pops. Without it, ret behaves as br.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall, instr_valid       enable = instr_valid & ~stall
//   branch_control_signal    branch class
//   ins_func_code            function within class
//   alu_flag                 [2]=carry [1]=negative [0]=zero
//   dest_addr, reg1          immediate target, register target
//   pc_out                   current PC
//   taken, link_wr           one-cycle pulses: redirect, write link_addr to ra
//   link_addr                pc_out+1 captured at bl
//   branch_cnt               saturating taken-redirect count
//   ras_empty/full/underflow return-address stack status
module pc_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                CNT_W     = 16,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              instr_valid,
   input  logic [1:0]        branch_control_signal,
   input  logic [5:0]        ins_func_code,
   input  logic [2:0]        alu_flag,
   input  logic [ADDR_W-1:0] dest_addr,
   input  logic [ADDR_W-1:0] reg1,
   output logic [ADDR_W-1:0] pc_out,
   output logic              taken,
   output logic              link_wr,
   output logic [ADDR_W-1:0] link_addr,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_underflow
);

   localparam int RAS_CNT_W = $clog2(RAS_DEPTH) + 1;

   logic                 en;
   logic [ADDR_W-1:0]    seq;
   logic [ADDR_W-1:0]    nxt_pc;
   logic                 nxt_taken;
   logic                 is_bl;
   logic [RAS_CNT_W-1:0] ras_cnt;

   assign en  = instr_valid & ~stall;
   assign seq = pc_out + ADDR_W'(1);

   // Status is derived from the entry count in both builds; without the
   // stack the count is constant zero, giving empty=1, full=0.
   assign ras_empty = (ras_cnt == '0);
   assign ras_full  = (ras_cnt == RAS_CNT_W'(RAS_DEPTH));

`ifdef PC_SEQ_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic [ADDR_W-1:0]    ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]     ras_wp;      // next slot to write; wp-1 is the top
   logic [RAS_CNT_W-1:0] ras_cnt_q;
   logic                 ras_uf_q;
   logic [ADDR_W-1:0]    ras_top;
   logic                 is_ret;

   assign ras_cnt       = ras_cnt_q;
   assign ras_underflow = ras_uf_q;
   assign ras_top       = ras_mem[ras_wp - PTR_W'(1)];
`else
   assign ras_cnt       = '0;
   assign ras_underflow = 1'b0;
`endif

   always_comb begin
      nxt_pc    = seq;
      nxt_taken = 1'b0;
      is_bl     = 1'b0;
`ifdef PC_SEQ_RAS_EN
      is_ret    = 1'b0;
`endif
      case (branch_control_signal)
         2'b00: begin
            case (ins_func_code)
               6'd0: begin nxt_pc = reg1; nxt_taken = 1'b1; end
               6'd1: if (alu_flag[1])  begin nxt_pc = dest_addr; nxt_taken = 1'b1; end
               6'd2: if (alu_flag[0])  begin nxt_pc = dest_addr; nxt_taken = 1'b1; end
               6'd3: if (!alu_flag[0]) begin nxt_pc = dest_addr; nxt_taken = 1'b1; end
               default: ;
            endcase
         end
         2'b01: begin
            case (ins_func_code)
               6'd0: begin nxt_pc = dest_addr; nxt_taken = 1'b1; end
               6'd1: if (alu_flag[2])  begin nxt_pc = dest_addr; nxt_taken = 1'b1; end
               6'd2: if (!alu_flag[2]) begin nxt_pc = dest_addr; nxt_taken = 1'b1; end
               default: ;
            endcase
         end
         2'b10: begin
            case (ins_func_code)
               6'd0: begin nxt_pc = dest_addr; nxt_taken = 1'b1; is_bl = 1'b1; end
               6'd1: begin
                  nxt_taken = 1'b1;
`ifdef PC_SEQ_RAS_EN
                  is_ret = 1'b1;
                  // An empty stack falls back to the register target.
                  nxt_pc = ras_empty ? reg1 : ras_top;
`else
                  nxt_pc = reg1;
`endif
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_out     <= RESET_PC;
         taken      <= 1'b0;
         link_wr    <= 1'b0;
         link_addr  <= '0;
         branch_cnt <= '0;
      end else begin
         taken   <= en & nxt_taken;
         link_wr <= en & is_bl;
         if (en) begin
            pc_out <= nxt_pc;
            if (is_bl) link_addr <= seq;
            if (nxt_taken && branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
         end
      end
   end

`ifdef PC_SEQ_RAS_EN
   // Entry storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (en && is_bl) ras_mem[ras_wp] <= seq;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ras_wp    <= '0;
         ras_cnt_q <= '0;
         ras_uf_q  <= 1'b0;
      end else if (en) begin
         if (is_bl) begin
            // A push when full overwrites the oldest slot, which is ras_wp.
            ras_wp <= ras_wp + PTR_W'(1);
            if (!ras_full) ras_cnt_q <= ras_cnt_q + RAS_CNT_W'(1);
         end else if (is_ret) begin
            if (ras_empty) begin
               ras_uf_q <= 1'b1;
            end else begin
               ras_wp    <= ras_wp - PTR_W'(1);
               ras_cnt_q <= ras_cnt_q - RAS_CNT_W'(1);
            end
         end
      end
   end
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for KGP-RISC; successor to the combinational branch-resolution logic.
- Each enabled cycle it decodes branch_control_signal, ins_func_code and ALU flags, then updates the PC register.
- Emits a one-cycle taken/flush pulse, link-register write data for bl, and a saturating taken-branch counter.
- Address width and counter width are parametrised; an optional return-address stack adds a ret instruction.

Parameters:
- ADDR_W, 32, width of pc_out, dest_addr, reg1, link_addr
- RESET_PC, 0, value loaded into pc_out on reset
- CNT_W, 16, width of branch_cnt
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2); used only with RAS_EN

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  1 = hold all state this cycle
- instr_valid  in  1  1 = decode inputs describe a real instruction
- branch_control_signal  in  2  branch class (00/01/10/11)
- ins_func_code  in  6  function code within class
- alu_flag  in  3  [2]=carry, [1]=negative, [0]=zero
- dest_addr  in  ADDR_W  immediate/label target
- reg1  in  ADDR_W  register target for br
- pc_out  out  ADDR_W  current PC (registered)
- taken  out  1  registered 1-cycle pulse: last update was a redirect
- link_wr  out  1  registered 1-cycle pulse: write link_addr to ra
- link_addr  out  ADDR_W  pc_out+1 captured at bl
- branch_cnt  out  CNT_W  saturating count of taken redirects
- ras_empty, ras_full, ras_underflow  out  1 each  RAS status (tied 1/0/0 without RAS_EN)

Behaviour:
- Reset (rst=0, async): pc_out=RESET_PC; taken=0, link_wr=0, link_addr=0, branch_cnt=0. RAS pointer/count=0, so ras_empty=1, ras_full=0, ras_underflow=0. Reset mid-stall or mid-branch discards everything.
- en = instr_valid & ~stall.
- en=0: pc_out, link_addr, branch_cnt and RAS hold; taken and link_wr are 0 next cycle.
- en=1: pc_out <= target on the next edge (latency 1). seq = pc_out+1, mod 2^ADDR_W (wraps to 0).
- Decoding, class/func → target:
  - 00/000000 br → reg1
  - 00/000001 bltz → dest_addr if flag[1], else seq
  - 00/000010 bz → dest_addr if flag[0], else seq
  - 00/000011 bnz → dest_addr if !flag[0], else seq
  - 01/000000 b → dest_addr
  - 01/000001 bcy → dest_addr if flag[2], else seq
  - 01/000010 bncy → dest_addr if !flag[2], else seq
  - 10/000000 bl → dest_addr; link_addr <= seq, link_wr <= 1
  - 10/000001 ret → see RAS_EN
  - 11/any → seq
  - Any other class/func pair → seq, not taken.
- taken <= 1 iff a branch/jump condition held. A taken branch whose target equals seq still counts as taken.
- branch_cnt increments on taken and saturates at 2^CNT_W-1; no wrap.

Optional Feature:
- Macro: PC_SEQ_RAS_EN.
- Defined: circular stack of RAS_DEPTH entries.
  - bl pushes seq. When full, a push overwrites the oldest entry; ras_full stays 1.
  - ret: if not empty, pops and jumps to the popped value with taken=1. If empty, jumps to reg1 with taken=1 and sets ras_underflow, which is sticky until reset.
  - Stalled cycles neither push nor pop.
  - ras_empty and ras_full are combinational from the entry count.
- Undefined: no stack storage; ret behaves exactly as br (→ reg1, taken=1); ras_empty=1, ras_full=0, ras_underflow=0.

Test Plan:
- Reset with RESET_PC=0x100, release, then 3 cycles of class 11 → pc_out 0x100,0x101,0x102,0x103; taken=0; branch_cnt=0.
- pc=0x20, bz with flag=001, dest=0x80 → pc=0x80, taken pulses 1 cycle, branch_cnt=1. Repeat with flag=000 → pc=0x81, taken=0.
- pc=0x40, bl to 0x200 with stall=1 for 2 cycles, then stall=0 → pc holds 0x40 during the stall. Then pc=0x200, link_wr=1 once, link_addr=0x41.
- pc=0xFFFFFFFF, class 11 → pc=0x0. CNT_W=2 with 5 taken b → branch_cnt stops at 3.
- RAS_EN, DEPTH=4, 5 bl then 5 ret → first 4 rets return the 4 newest links in LIFO order. The 5th ret jumps to reg1 and sets ras_underflow=1.
- Assert rst low asynchronously between edges while a bl is pending → all outputs reach reset values immediately; no link_wr pulse after release.
